// File: rtl/mips_core_pkg.sv
// mips_core_pkg: shared default sizing constants for the MIPS core.
// The issue queue takes these as parameter defaults:
//   IQ_DEPTH     - issue queue entries
//   IQ_NUM_SRC   - source operands per instruction
//   IQ_WB_PORTS  - writeback wakeup broadcast ports
//   PHYS_TAG_W   - physical register tag width
//   AL_IDX_W     - active-list index width
//   IQ_PAYLOAD_W - opaque decoded-instruction payload width
package mips_core_pkg;

    localparam int unsigned IQ_DEPTH     = 16;
    localparam int unsigned IQ_NUM_SRC   = 2;
    localparam int unsigned IQ_WB_PORTS  = 2;
    localparam int unsigned PHYS_TAG_W   = 6;
    localparam int unsigned AL_IDX_W     = 5;
    localparam int unsigned IQ_PAYLOAD_W = 64;

endpackage

// File: rtl/iq_select.sv
// iq_select: fixed-priority picker, lowest index wins.
// Ports:
//   req   in  N        request vector
//   grant out N        one-hot grant (all zero when no request)
//   idx   out log2(N)  index of the granted request (0 when none)
//   any   out 1        at least one request present
module iq_select #(
    parameter int unsigned N = 16
) (
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int unsigned IDX_W = $clog2(N);

    logic found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i] && !found) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
            end
        end
        any = found;
    end

endmodule

// File: rtl/issue_queue.sv
// issue_queue: age-ordered collapsing out-of-order issue queue.
// Entries 0..count-1 are valid, index 0 is the oldest. Each cycle the oldest
// entry with all sources ready is presented on issue_*; when accepted, the
// younger entries shift down by one. Writeback broadcasts set source ready
// bits, including for sources being dispatched in the same cycle.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   flush                         drop all entries (takes effect next cycle)
//   dispatch_valid/_ready         dispatch handshake (ready = count < DEPTH)
//   dispatch_payload/_src_tag/_src_rdy/_dst_tag/_al_idx  dispatched fields
//   wb_valid, wb_tag              writeback tag broadcasts, one per port
//   issue_valid/_ready            issue handshake
//   issue_payload/_dst_tag/_al_idx  fields of the selected entry
//   count                         occupied entries
// Configuration macro IQ_SAME_CYCLE_WAKEUP_EN: when defined, selection also
// sees the current cycle's broadcast matches (combinational wb -> issue path).
module issue_queue
    import mips_core_pkg::*;
#(
    parameter int unsigned DEPTH     = IQ_DEPTH,
    parameter int unsigned NUM_SRC   = IQ_NUM_SRC,
    parameter int unsigned WB_PORTS  = IQ_WB_PORTS,
    parameter int unsigned TAG_W     = PHYS_TAG_W,
    parameter int unsigned AL_W      = AL_IDX_W,
    parameter int unsigned PAYLOAD_W = IQ_PAYLOAD_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       dispatch_valid,
    output logic                       dispatch_ready,
    input  logic [PAYLOAD_W-1:0]       dispatch_payload,
    input  logic [NUM_SRC*TAG_W-1:0]   dispatch_src_tag,
    input  logic [NUM_SRC-1:0]         dispatch_src_rdy,
    input  logic [TAG_W-1:0]           dispatch_dst_tag,
    input  logic [AL_W-1:0]            dispatch_al_idx,
    input  logic [WB_PORTS-1:0]        wb_valid,
    input  logic [WB_PORTS*TAG_W-1:0]  wb_tag,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [PAYLOAD_W-1:0]       issue_payload,
    output logic [TAG_W-1:0]           issue_dst_tag,
    output logic [AL_W-1:0]            issue_al_idx,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic                            valid;
        logic [PAYLOAD_W-1:0]            payload;
        logic [NUM_SRC-1:0][TAG_W-1:0]   src_tag;
        logic [NUM_SRC-1:0]              src_rdy;
        logic [TAG_W-1:0]                dst_tag;
        logic [AL_W-1:0]                 al_idx;
    } entry_t;

    entry_t            entries_q [DEPTH];
    entry_t            entries_d [DEPTH];
    // One extra always-empty slot so the shift of the top entry reads '0.
    entry_t            woken     [DEPTH+1];
    entry_t            disp_entry;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [CNT_W-1:0]  wr_idx;
    logic [DEPTH-1:0]  req;
    logic [DEPTH-1:0]  sel_grant;
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_any;
    logic              issue_fire;
    logic              dispatch_fire;
    logic              shifting;

    // Stored entries with this cycle's broadcasts folded into their ready bits.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            woken[i] = entries_q[i];
            for (int unsigned s = 0; s < NUM_SRC; s++) begin
                for (int unsigned p = 0; p < WB_PORTS; p++) begin
                    if (entries_q[i].valid && wb_valid[p] &&
                        wb_tag[p*TAG_W +: TAG_W] == entries_q[i].src_tag[s]) begin
                        woken[i].src_rdy[s] = 1'b1;
                    end
                end
            end
        end
        woken[DEPTH] = '0;
    end

    // Incoming entry, with same-cycle broadcast capture.
    always_comb begin
        disp_entry         = '0;
        disp_entry.valid   = 1'b1;
        disp_entry.payload = dispatch_payload;
        disp_entry.dst_tag = dispatch_dst_tag;
        disp_entry.al_idx  = dispatch_al_idx;
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
            disp_entry.src_tag[s] = dispatch_src_tag[s*TAG_W +: TAG_W];
            disp_entry.src_rdy[s] = dispatch_src_rdy[s];
            for (int unsigned p = 0; p < WB_PORTS; p++) begin
                if (wb_valid[p] && wb_tag[p*TAG_W +: TAG_W] == dispatch_src_tag[s*TAG_W +: TAG_W]) begin
                    disp_entry.src_rdy[s] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
`ifdef IQ_SAME_CYCLE_WAKEUP_EN
            req[i] = woken[i].valid && (&woken[i].src_rdy);
`else
            req[i] = entries_q[i].valid && (&entries_q[i].src_rdy);
`endif
        end
    end

    iq_select #(.N(DEPTH)) u_select (
        .req   (req),
        .grant (sel_grant),
        .idx   (sel_idx),
        .any   (sel_any)
    );

    assign dispatch_ready = (count_q < CNT_W'(DEPTH));
    assign issue_valid    = sel_any && !flush;
    assign issue_fire     = issue_valid && issue_ready;
    assign dispatch_fire  = dispatch_valid && dispatch_ready && !flush;
    assign issue_payload  = issue_valid ? entries_q[sel_idx].payload : '0;
    assign issue_dst_tag  = issue_valid ? entries_q[sel_idx].dst_tag : '0;
    assign issue_al_idx   = issue_valid ? entries_q[sel_idx].al_idx  : '0;
    assign count          = count_q;

    // An issue in the same cycle frees the top slot, so the new entry lands one lower.
    assign wr_idx = count_q - CNT_W'(issue_fire);

    always_comb begin
        shifting = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            // Every slot at or above the granted one takes its upper neighbour.
            shifting = shifting || sel_grant[i];
            if (issue_fire && shifting) begin
                entries_d[i] = woken[i+1];
            end else begin
                entries_d[i] = woken[i];
            end
            if (dispatch_fire && CNT_W'(i) == wr_idx) begin
                entries_d[i] = disp_entry;
            end
            if (flush) begin
                entries_d[i] = '0;
            end
        end
    end

    always_comb begin
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(dispatch_fire) - CNT_W'(issue_fire);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: randomized and directed stimulus for issue_queue (DEPTH=8),
// checked every cycle against a queue-based reference model of the issue queue
// rules. Follows IQ_SAME_CYCLE_WAKEUP_EN if it is defined for the build.
module tb_issue_queue;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned NSRC  = 2;
    localparam int unsigned WBP   = 2;
    localparam int unsigned TW    = 6;
    localparam int unsigned AW    = 5;
    localparam int unsigned PW    = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush;
    logic            d_valid;
    logic            d_ready;
    logic [PW-1:0]   d_payload;
    logic [2*TW-1:0] d_tag;
    logic [1:0]      d_rdy;
    logic [TW-1:0]   d_dst;
    logic [AW-1:0]   d_al;
    logic [1:0]      wbv;
    logic [2*TW-1:0] wbt;
    logic            i_valid;
    logic            i_ready;
    logic [PW-1:0]   i_payload;
    logic [TW-1:0]   i_dst;
    logic [AW-1:0]   i_al;
    logic [3:0]      cnt;

    issue_queue #(
        .DEPTH(DEPTH), .NUM_SRC(NSRC), .WB_PORTS(WBP),
        .TAG_W(TW), .AL_W(AW), .PAYLOAD_W(PW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush            (flush),
        .dispatch_valid   (d_valid),
        .dispatch_ready   (d_ready),
        .dispatch_payload (d_payload),
        .dispatch_src_tag (d_tag),
        .dispatch_src_rdy (d_rdy),
        .dispatch_dst_tag (d_dst),
        .dispatch_al_idx  (d_al),
        .wb_valid         (wbv),
        .wb_tag           (wbt),
        .issue_valid      (i_valid),
        .issue_ready      (i_ready),
        .issue_payload    (i_payload),
        .issue_dst_tag    (i_dst),
        .issue_al_idx     (i_al),
        .count            (cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] payload;
        logic [TW-1:0] tag0;
        logic [TW-1:0] tag1;
        bit            rdy0;
        bit            rdy1;
        logic [TW-1:0] dst;
        logic [AW-1:0] al;
    } instr_t;

    instr_t model_q[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    int     exp_sel;
    logic [PW-1:0] next_payload = 16'h1000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit wb_hit(input logic [TW-1:0] t);
        return (wbv[0] && wbt[TW-1:0] == t) || (wbv[1] && wbt[2*TW-1:TW] == t);
    endfunction

    // Oldest entry whose sources are both available, or -1.
    function automatic int oldest_ready();
        bit same_cycle = 1'b0;
`ifdef IQ_SAME_CYCLE_WAKEUP_EN
        same_cycle = 1'b1;
`endif
        for (int k = 0; k < model_q.size(); k++) begin
            if ((model_q[k].rdy0 || (same_cycle && wb_hit(model_q[k].tag0))) &&
                (model_q[k].rdy1 || (same_cycle && wb_hit(model_q[k].tag1))))
                return k;
        end
        return -1;
    endfunction

    // Compare this cycle's outputs, then advance model and DUT by one edge.
    task automatic tick();
        bit exp_iv;
        bit fire_i;
        bit fire_d;
        instr_t n;
        #1;
        exp_sel = oldest_ready();
        exp_iv  = (exp_sel >= 0) && !flush;
        check("count", 32'(cnt), 32'(model_q.size()));
        check("dispatch_ready", 32'(d_ready), 32'(model_q.size() < DEPTH));
        check("issue_valid", 32'(i_valid), 32'(exp_iv));
        if (exp_iv) begin
            check("issue_payload", 32'(i_payload), 32'(model_q[exp_sel].payload));
            check("issue_dst_tag", 32'(i_dst), 32'(model_q[exp_sel].dst));
            check("issue_al_idx", 32'(i_al), 32'(model_q[exp_sel].al));
        end
        @(posedge clk);
        if (flush) begin
            model_q.delete();
        end else begin
            fire_i = exp_iv && i_ready;
            fire_d = d_valid && (model_q.size() < DEPTH);
            if (fire_i) model_q.delete(exp_sel);
            foreach (model_q[k]) begin
                if (wb_hit(model_q[k].tag0)) model_q[k].rdy0 = 1'b1;
                if (wb_hit(model_q[k].tag1)) model_q[k].rdy1 = 1'b1;
            end
            if (fire_d) begin
                n.payload = d_payload;
                n.tag0    = d_tag[TW-1:0];
                n.tag1    = d_tag[2*TW-1:TW];
                n.rdy0    = d_rdy[0] || wb_hit(n.tag0);
                n.rdy1    = d_rdy[1] || wb_hit(n.tag1);
                n.dst     = d_dst;
                n.al      = d_al;
                model_q.push_back(n);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        flush = 0; d_valid = 0; d_payload = '0; d_tag = '0; d_rdy = '0;
        d_dst = '0; d_al = '0; wbv = '0; wbt = '0; i_ready = 0;
    endtask

    task automatic set_disp(input logic [TW-1:0] t0, input logic [TW-1:0] t1, input logic [1:0] r);
        d_valid   = 1'b1;
        next_payload++;
        d_payload = next_payload;
        d_tag     = {t1, t0};
        d_rdy     = r;
        d_dst     = TW'($urandom);
        d_al      = AW'($urandom);
    endtask

    task automatic rand_cycle();
        idle();
        flush   = ($urandom_range(0, 49) == 0);
        i_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 2) != 0)
            set_disp(TW'($urandom_range(0, 7)), TW'($urandom_range(0, 7)), 2'($urandom));
        wbv = 2'($urandom);
        wbt = {TW'($urandom_range(0, 7)), TW'($urandom_range(0, 7))};
        tick();
    endtask

    initial begin
        idle();
        repeat (2) @(negedge clk);
        check("reset count", 32'(cnt), 0);
        check("reset dispatch_ready", 32'(d_ready), 1);
        check("reset issue_valid", 32'(i_valid), 0);
        check("reset issue_payload", 32'(i_payload), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // A, B, C all ready back to back with issue_ready held.
        for (int k = 0; k < 3; k++) begin
            idle(); i_ready = 1; set_disp(6'd1, 6'd2, 2'b11); tick();
        end
        for (int k = 0; k < 3; k++) begin
            idle(); i_ready = 1; tick();
        end

        // X waits on tag 5, Y all ready; Y issues first, then broadcast wakes X.
        idle(); set_disp(6'd5, 6'd3, 2'b10); tick();
        idle(); set_disp(6'd4, 6'd3, 2'b11); tick();
        idle(); i_ready = 1; tick();
        idle(); i_ready = 1; wbv = 2'b01; wbt = {6'd0, 6'd5}; tick();
        for (int k = 0; k < 2; k++) begin
            idle(); i_ready = 1; tick();
        end

        // Fill, hold dispatch, release one issue.
        for (int k = 0; k < 10; k++) begin
            idle(); set_disp(6'd1, 6'd1, 2'b11); tick();
        end
        idle(); set_disp(6'd1, 6'd1, 2'b11); i_ready = 1; tick();
        for (int k = 0; k < 2; k++) begin
            idle(); set_disp(6'd1, 6'd1, 2'b11); tick();
        end

        // Flush with dispatch and issue requested.
        idle(); set_disp(6'd1, 6'd1, 2'b11); i_ready = 1; flush = 1; tick();
        idle(); tick();

        // Dispatch capture of a same-cycle broadcast on port 1.
        idle(); set_disp(6'd9, 6'd2, 2'b10); wbv = 2'b10; wbt = {6'd9, 6'd0}; tick();
        idle(); i_ready = 1; tick();
        idle(); tick();

        for (int k = 0; k < 1500; k++) rand_cycle();

        // Asynchronous reset mid-operation.
        for (int k = 0; k < 6; k++) begin
            idle(); set_disp(6'd1, 6'd1, 2'b11); tick();
        end
        #2 rst_n = 1'b0;
        #1;
        check("async reset count", 32'(cnt), 0);
        check("async reset issue_valid", 32'(i_valid), 0);
        model_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 500; k++) rand_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
